// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

  localparam int unsigned TimeoutDefault = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester and SPI-master signal bundle for spi_arbiter.
// slave: arbiter side. master: requesters plus SPI master (environment side).
interface spi_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_wr;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_err;
  logic [7:0]        rsp_dout;
  logic              m_rst;
  logic              m_wr;
  logic [7:0]        m_addr;
  logic [7:0]        m_din;
  logic              m_done;
  logic              m_err;
  logic [7:0]        m_dout;

  modport slave (
    input  req_valid, req_wr, req_addr, req_din, m_done, m_err, m_dout,
    output req_ready, rsp_valid, rsp_err, rsp_dout, m_rst, m_wr, m_addr, m_din
  );

  modport master (
    output req_valid, req_wr, req_addr, req_din, m_done, m_err, m_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_dout, m_rst, m_wr, m_addr, m_din
  );
endinterface

// File: rtl/spi_rr_picker.sv
// Combinational round-robin priority encoder: searches upward from last_i+1 with wrap.
module spi_rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] cand;

  // First set request after last_i in circular order wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdxW'((32'(last_i) + i) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// Optional WAIT-state abort timer enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic          clk,
  input  logic          rst,
  spi_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [IdxW-1:0] last_grant_q;
  logic [IdxW-1:0] owner_q;
  logic [NREQ-1:0] req_ready_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            rsp_err_q;
  logic [7:0]      rsp_dout_q;
  logic            m_rst_q;
  logic            m_wr_q;
  logic [7:0]      m_addr_q;
  logic [7:0]      m_din_q;

  logic [NREQ-1:0] pick_grant;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  logic [TimerW-1:0] timer_q;
  logic              timeout_hit;
  assign timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));
`endif

  spi_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i   (bus.req_valid),
    .last_i  (last_grant_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Transaction FSM; every output is a register loaded on the edge entering its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NREQ - 1);
      owner_q      <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_dout_q   <= 8'h00;
      m_rst_q      <= 1'b1;
      m_wr_q       <= 1'b0;
      m_addr_q     <= 8'h00;
      m_din_q      <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|bus.req_valid) state_q <= StArb;
        end
        StArb: begin
          // Requests may be withdrawn before arbitration; keep last_grant then.
          if (pick_valid) begin
            m_wr_q       <= bus.req_wr[pick_idx];
            m_addr_q     <= bus.req_addr[8*pick_idx +: 8];
            m_din_q      <= bus.req_din[8*pick_idx +: 8];
            owner_q      <= pick_idx;
            last_grant_q <= pick_idx;
            req_ready_q  <= pick_grant;
            m_rst_q      <= 1'b0;
            state_q      <= StIssue;
          end else begin
            state_q <= StIdle;
          end
        end
        StIssue: begin
`ifdef SPI_ARB_TIMEOUT_EN
          timer_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          // m_done wins over a coincident timeout.
          if (bus.m_done) begin
            rsp_err_q   <= bus.m_err;
            rsp_dout_q  <= m_wr_q ? 8'h00 : bus.m_dout;
            rsp_valid_q <= NREQ'(1) << owner_q;
            m_rst_q     <= 1'b1;
            state_q     <= StResp;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_err_q   <= 1'b1;
            rsp_dout_q  <= 8'h00;
            rsp_valid_q <= NREQ'(1) << owner_q;
            m_rst_q     <= 1'b1;
            state_q     <= StResp;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive the bundle from the registered outputs.
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dout  = rsp_dout_q;
  assign bus.m_rst     = m_rst_q;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_din     = m_din_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (NREQ=4, TIMEOUT=16).
module tb_spi_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  spi_arbiter_if #(.NREQ(4)) bus ();

  spi_arbiter #(
    .NREQ    (4),
    .TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Polls at negedges until a req_ready pulse appears (state ISSUE) or the budget runs out.
  task automatic wait_ready(output logic [3:0] v, output int cycles);
    v = 4'b0000;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles = i + 1;
      if (bus.req_ready !== 4'b0000) begin
        v = bus.req_ready;
        return;
      end
    end
  endtask

  // From the ISSUE negedge: complete in the first WAIT cycle, return at the RESP negedge.
  task automatic complete(input logic [7:0] dout, input logic err);
    @(negedge clk);
    bus.m_done = 1'b1;
    bus.m_err  = err;
    bus.m_dout = dout;
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_err  = 1'b0;
    bus.m_dout = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.m_rst !== 1'b1) $display("FAIL reset_m_rst: got %b expected 1", bus.m_rst); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_dout !== 8'h00) $display("FAIL reset_rsp_dout: got %h expected 00", bus.rsp_dout); else n_pass++;
    n_checks++; if (bus.m_wr !== 1'b0) $display("FAIL reset_m_wr: got %b expected 0", bus.m_wr); else n_pass++;
    n_checks++; if (bus.m_addr !== 8'h00) $display("FAIL reset_m_addr: got %h expected 00", bus.m_addr); else n_pass++;
    n_checks++; if (bus.m_din !== 8'h00) $display("FAIL reset_m_din: got %h expected 00", bus.m_din); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    logic [3:0] v;
    int cyc;
    bus.req_wr    = 4'b0010;
    bus.req_addr  = 32'h0000_0500;
    bus.req_din   = 32'h0000_A500;
    bus.req_valid = 4'b0010;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b0010) $display("FAIL wr_ready: got %b expected 0010", v); else n_pass++;
    n_checks++; if (bus.m_addr !== 8'h05) $display("FAIL wr_m_addr: got %h expected 05", bus.m_addr); else n_pass++;
    n_checks++; if (bus.m_din !== 8'hA5) $display("FAIL wr_m_din: got %h expected a5", bus.m_din); else n_pass++;
    n_checks++; if (bus.m_wr !== 1'b1) $display("FAIL wr_m_wr: got %b expected 1", bus.m_wr); else n_pass++;
    n_checks++; if (bus.m_rst !== 1'b0) $display("FAIL wr_m_rst_issue: got %b expected 0", bus.m_rst); else n_pass++;
    bus.req_valid = 4'b0000;
    complete(8'h3C, 1'b0);
    n_checks++; if (bus.rsp_valid !== 4'b0010) $display("FAIL wr_rsp_valid: got %b expected 0010", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL wr_rsp_err: got %b expected 0", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_dout !== 8'h00) $display("FAIL wr_rsp_dout: got %h expected 00", bus.rsp_dout); else n_pass++;
    n_checks++; if (bus.m_rst !== 1'b1) $display("FAIL wr_m_rst_resp: got %b expected 1", bus.m_rst); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 4'b0000) $display("FAIL wr_rsp_pulse_width: got %b expected 0000", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_single_read();
    logic [3:0] v;
    int cyc;
    bus.req_wr    = 4'b0000;
    bus.req_addr  = 32'h0005_0000;
    bus.req_din   = 32'h0000_0000;
    bus.req_valid = 4'b0100;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b0100) $display("FAIL rd_ready: got %b expected 0100", v); else n_pass++;
    n_checks++; if (bus.m_wr !== 1'b0) $display("FAIL rd_m_wr: got %b expected 0", bus.m_wr); else n_pass++;
    bus.req_valid = 4'b0000;
    complete(8'hA5, 1'b0);
    n_checks++; if (bus.rsp_valid !== 4'b0100) $display("FAIL rd_rsp_valid: got %b expected 0100", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_dout !== 8'hA5) $display("FAIL rd_rsp_dout: got %h expected a5", bus.rsp_dout); else n_pass++;
  endtask

  // A request dropped before ARB samples it must not grant or move last_grant (still 2).
  task automatic test_withdraw();
    logic [3:0] v;
    int cyc;
    int pulses;
    repeat (2) @(negedge clk);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 4'b0000) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL withdraw_no_pulse: got %0d expected 0", pulses); else n_pass++;
    bus.req_wr    = 4'b0000;
    bus.req_valid = 4'b1011;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b1000) $display("FAIL withdraw_next_grant: got %b expected 1000", v); else n_pass++;
    bus.req_valid = 4'b0000;
    complete(8'h11, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [3:0] v;
    logic [3:0] exp_v;
    logic [7:0] exp_a;
    int cyc;
    int spacing;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    bus.req_wr    = 4'b0000;
    bus.req_addr  = 32'h1312_1110;
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_v = 4'b0001 << order[k];
      exp_a = 8'h10 + 8'(order[k]);
      wait_ready(v, cyc);
      spacing = cyc + 2;
      n_checks++; if (v !== exp_v) $display("FAIL rr_grant%0d: got %b expected %b", k, v, exp_v); else n_pass++;
      n_checks++; if (bus.m_addr !== exp_a) $display("FAIL rr_addr%0d: got %h expected %h", k, bus.m_addr, exp_a); else n_pass++;
      if (k > 0) begin
        n_checks++; if (spacing !== 5) $display("FAIL rr_spacing%0d: got %0d expected 5", k, spacing); else n_pass++;
      end
      complete(8'h50 + 8'(k), 1'b0);
      n_checks++; if (bus.rsp_valid !== exp_v) $display("FAIL rr_rsp%0d: got %b expected %b", k, bus.rsp_valid, exp_v); else n_pass++;
      n_checks++; if (bus.rsp_dout !== 8'h50 + 8'(k)) $display("FAIL rr_dout%0d: got %h expected %h", k, bus.rsp_dout, 8'h50 + 8'(k)); else n_pass++;
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_master_error();
    logic [3:0] v;
    int cyc;
    bus.req_wr    = 4'b1000;
    bus.req_addr  = 32'h4000_0021;
    bus.req_din   = 32'h5A00_0000;
    bus.req_valid = 4'b1000;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b1000) $display("FAIL err_ready: got %b expected 1000", v); else n_pass++;
    n_checks++; if (bus.m_addr !== 8'h40) $display("FAIL err_m_addr: got %h expected 40", bus.m_addr); else n_pass++;
    bus.req_valid = 4'b0000;
    complete(8'h77, 1'b1);
    n_checks++; if (bus.rsp_valid !== 4'b1000) $display("FAIL err_rsp_valid: got %b expected 1000", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b1) $display("FAIL err_rsp_err: got %b expected 1", bus.rsp_err); else n_pass++;
    bus.req_wr    = 4'b0000;
    bus.req_valid = 4'b0001;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b0001) $display("FAIL err_next_ready: got %b expected 0001", v); else n_pass++;
    n_checks++; if (bus.m_addr !== 8'h21) $display("FAIL err_next_addr: got %h expected 21", bus.m_addr); else n_pass++;
    bus.req_valid = 4'b0000;
    complete(8'h99, 1'b0);
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL err_next_rsp_err: got %b expected 0", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_dout !== 8'h99) $display("FAIL err_next_dout: got %h expected 99", bus.rsp_dout); else n_pass++;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] v;
    int cyc;
    int n;
    bus.req_wr    = 4'b0000;
    bus.req_valid = 4'b0010;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b0010) $display("FAIL to_ready: got %b expected 0010", v); else n_pass++;
    bus.req_valid = 4'b0000;
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000) begin
        n = i;
        break;
      end
    end
    // 16 WAIT cycles, then the RESP cycle.
    n_checks++; if (n !== 17) $display("FAIL to_latency: got %0d expected 17", n); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 4'b0010) $display("FAIL to_rsp_valid: got %b expected 0010", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b1) $display("FAIL to_rsp_err: got %b expected 1", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_dout !== 8'h00) $display("FAIL to_rsp_dout: got %h expected 00", bus.rsp_dout); else n_pass++;
    n_checks++; if (bus.m_rst !== 1'b1) $display("FAIL to_m_rst: got %b expected 1", bus.m_rst); else n_pass++;
    // m_done on the 16th WAIT cycle beats the timeout.
    bus.req_valid = 4'b0100;
    wait_ready(v, cyc);
    bus.req_valid = 4'b0000;
    repeat (16) @(negedge clk);
    bus.m_done = 1'b1;
    bus.m_dout = 8'hC3;
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_dout = 8'h00;
    n_checks++; if (bus.rsp_valid !== 4'b0100) $display("FAIL to_done_valid: got %b expected 0100", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL to_done_err: got %b expected 0", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_dout !== 8'hC3) $display("FAIL to_done_dout: got %h expected c3", bus.rsp_dout); else n_pass++;
  endtask
`endif

  task automatic test_reset_in_wait();
    logic [3:0] v;
    int cyc;
    int pulses;
    bus.req_wr    = 4'b0100;
    bus.req_addr  = 32'h0033_0000;
    bus.req_din   = 32'h0044_0000;
    bus.req_valid = 4'b0100;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b0100) $display("FAIL rw_ready: got %b expected 0100", v); else n_pass++;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.m_rst !== 1'b1) $display("FAIL rw_m_rst: got %b expected 1", bus.m_rst); else n_pass++;
    n_checks++; if (bus.m_addr !== 8'h00) $display("FAIL rw_m_addr: got %h expected 00", bus.m_addr); else n_pass++;
    n_checks++; if (bus.m_din !== 8'h00) $display("FAIL rw_m_din: got %h expected 00", bus.m_din); else n_pass++;
    n_checks++; if (bus.m_wr !== 1'b0) $display("FAIL rw_m_wr: got %b expected 0", bus.m_wr); else n_pass++;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL rw_no_rsp: got %0d expected 0", pulses); else n_pass++;
    bus.req_wr    = 4'b0000;
    bus.req_valid = 4'b1111;
    wait_ready(v, cyc);
    n_checks++; if (v !== 4'b0001) $display("FAIL rw_next_grant: got %b expected 0001", v); else n_pass++;
    bus.req_valid = 4'b0000;
    complete(8'h66, 1'b0);
    n_checks++; if (bus.rsp_valid !== 4'b0001) $display("FAIL rw_next_rsp: got %b expected 0001", bus.rsp_valid); else n_pass++;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_wr    = 4'b0000;
    bus.req_addr  = 32'h0;
    bus.req_din   = 32'h0;
    bus.m_done    = 1'b0;
    bus.m_err     = 1'b0;
    bus.m_dout    = 8'h00;
    test_reset();
    test_single_write();
    test_single_read();
    test_withdraw();
    test_round_robin();
    test_master_error();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
